// File: rtl/laser_pkg.sv
// Shared link constants, lane count and receiver state encoding for the optical GPIO link.
package laser_pkg;
  localparam int LANES = 4;
  localparam logic [LANES-1:0] IDLE_SYM  = 4'hF;
  localparam logic [LANES-1:0] START_SYM = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    STOP
  } rx_state_t;
endpackage

// File: rtl/laser_sync2.sv
// Two-flop synchroniser for asynchronous lane pins; resets to all-ones so the link reads as idle.
module laser_sync2 #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/laser_rx.sv
// Receive deframer for the 4-lane optical link: start symbol, 2*WORD_W/4 data nibbles, stop symbol.
// Define LASER_RX_CHECKSUM_EN to expect an XOR checksum nibble between the data and the stop symbol.
module laser_rx
  import laser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int WORD_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LANES-1:0]  lane_in,
  output logic [WORD_W-1:0] data1_in,
  output logic [WORD_W-1:0] data2_in,
  output logic              data_valid,
  output logic              frame_err
);
  localparam int N     = 2 * WORD_W / LANES;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int NIB_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(N - 1);

  rx_state_t           state, next_state;
  logic [LANES-1:0]    s_lane;
  logic [CNT_W-1:0]    cnt;
  logic [NIB_W-1:0]    nib_cnt;
  logic [2*WORD_W-1:0] shreg;
  logic                csum_ok;
  logic                expire, shift_en, stop_smp, good;

  laser_sync2 #(.W(LANES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (lane_in),
    .q     (s_lane)
  );

  assign expire = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (s_lane == START_SYM) next_state = START;
      START: if (expire) next_state = (s_lane == START_SYM) ? DATA : IDLE;
`ifdef LASER_RX_CHECKSUM_EN
      DATA:  if (expire && nib_cnt == LAST_NIB) next_state = CHECK;
      CHECK: if (expire) next_state = STOP;
`else
      DATA:  if (expire && nib_cnt == LAST_NIB) next_state = STOP;
`endif
      STOP:  if (expire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == DATA) && expire;
    stop_smp = (state == STOP) && expire;
    good     = stop_smp && (s_lane == IDLE_SYM) && csum_ok;
  end

  // Bit timer is parked at the half-symbol value while idle so the start symbol is sampled mid-bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= HALF_LD;
      nib_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE) cnt <= HALF_LD;
      else if (expire)   cnt <= FULL_LD;
      else               cnt <= cnt - 1'b1;
      if (state == START)  nib_cnt <= '0;
      else if (shift_en)   nib_cnt <= nib_cnt + 1'b1;
      if (shift_en) shreg <= {shreg[2*WORD_W-LANES-1:0], s_lane};
    end
  end

`ifdef LASER_RX_CHECKSUM_EN
  logic [LANES-1:0] csum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum    <= '0;
      csum_ok <= 1'b0;
    end else begin
      if (state == START)  csum <= '0;
      else if (shift_en)   csum <= csum ^ s_lane;
      if (state == CHECK && expire) csum_ok <= (s_lane == csum);
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  // Result registers: pulses land one cycle after the stop sample, words update with data_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data1_in   <= '0;
      data2_in   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= good;
      frame_err  <= stop_smp && !good;
      if (good) begin
        data1_in <= shreg[2*WORD_W-1:WORD_W];
        data2_in <= shreg[WORD_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_laser_rx.sv
// Self-checking bench for laser_rx: table of directed frames, corner sequences and random frames.
module tb_laser_rx;
  localparam int CPB = 4;
  localparam int WW  = 8;
  localparam int NN  = 2 * WW / 4;
`ifdef LASER_RX_CHECKSUM_EN
  localparam int K    = 2;
  localparam bit CSUM = 1'b1;
`else
  localparam int K    = 1;
  localparam bit CSUM = 1'b0;
`endif
  // pin-to-pulse latency: synchroniser (2) + start half-symbol + symbols + output register
  localparam int LAT = 2 + CPB / 2 + (NN + K) * CPB + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    lane_in;
  logic [WW-1:0] data1_in, data2_in;
  logic          data_valid, frame_err;

  laser_rx #(.CLKS_PER_BIT(CPB), .WORD_W(WW)) dut (
    .clock      (clock),
    .reset      (reset),
    .lane_in    (lane_in),
    .data1_in   (data1_in),
    .data2_in   (data2_in),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int vcnt = 0, ecnt = 0, both = 0, pcyc = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] md1, md2;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (data_valid) begin vcnt = vcnt + 1; pcyc = cyc; end
    if (frame_err)  begin ecnt = ecnt + 1; pcyc = cyc; end
    if (data_valid && frame_err) both = both + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d1, d2;
    logic [3:0] chk, stop;
    bit         glitch;
    bit         exp_v;
    logic [7:0] e1, e2;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_sym(input logic [3:0] sym);
    lane_in = sym;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d1, input logic [7:0] d2, input logic [3:0] chk,
                           input logic [3:0] stop, output int nv, output int ne, output int lat);
    int v0, e0, s;
    v0 = vcnt; e0 = ecnt;
    @(posedge clock); #1;
    s = cyc;
    drive_sym(4'h0);
    drive_sym(d1[7:4]); drive_sym(d1[3:0]);
    drive_sym(d2[7:4]); drive_sym(d2[3:0]);
    if (CSUM) drive_sym(chk);
    drive_sym(stop);
    lane_in = 4'hF;
    repeat (12) @(posedge clock);
    #1;
    nv  = vcnt - v0;
    ne  = ecnt - e0;
    lat = (nv + ne > 0) ? pcyc - s : -1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [3:0] chk, input logic [3:0] stop, input bit exp_v,
                          input logic [7:0] e1, input logic [7:0] e2);
    int nv, ne, lat;
    run_frame(d1, d2, chk, stop, nv, ne, lat);
    check({tag, "_valid_cnt"}, nv, exp_v ? 1 : 0);
    check({tag, "_err_cnt"}, ne, exp_v ? 0 : 1);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data1"}, data1_in, e1);
    check({tag, "_data2"}, data2_in, e2);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] d1, d2;
    logic [3:0] x, chk, stop;
    bit ev;

    tbl[0] = '{8'hA5, 8'h3C, 4'h0, 4'hF, 1'b0, 1'b1, 8'hA5, 8'h3C};
    tbl[1] = '{8'hA5, 8'h3C, 4'h1, 4'hF, 1'b0, !CSUM, 8'hA5, 8'h3C};
    tbl[2] = '{8'h11, 8'h22, 4'h0, 4'hF, 1'b1, 1'b1, 8'h11, 8'h22};
    tbl[3] = '{8'h11, 8'h22, 4'h0, 4'h7, 1'b0, 1'b0, 8'h11, 8'h22};
    tbl[4] = '{8'hFF, 8'h00, 4'h0, 4'hF, 1'b0, 1'b1, 8'hFF, 8'h00};
    tbl[5] = '{8'h96, 8'hE1, 4'h0, 4'hF, 1'b0, 1'b1, 8'h96, 8'hE1};
    tbl[6] = '{8'h3C, 8'hA5, 4'h5, 4'hF, 1'b0, !CSUM,
               CSUM ? 8'h96 : 8'h3C, CSUM ? 8'hE1 : 8'hA5};

    reset = 1'b1;
    lane_in = 4'hF;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("rst_data1", data1_in, 0);
    check("rst_data2", data2_in, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", frame_err, 0);
    repeat (200) @(posedge clock);
    #1;
    check("idle_no_pulse", vcnt + ecnt, 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].glitch) begin
        v0 = vcnt; e0 = ecnt;
        @(posedge clock); #1 lane_in = 4'h0;
        @(posedge clock); #1 lane_in = 4'hF;
        repeat (12) @(posedge clock);
        #1;
        check($sformatf("row%0d_glitch_no_pulse", i), (vcnt - v0) + (ecnt - e0), 0);
      end
      do_frame($sformatf("row%0d", i), tbl[i].d1, tbl[i].d2, tbl[i].chk, tbl[i].stop,
               tbl[i].exp_v, tbl[i].e1, tbl[i].e2);
    end

    // reset arriving part-way through the data nibbles
    v0 = vcnt; e0 = ecnt;
    @(posedge clock); #1;
    drive_sym(4'h0);
    drive_sym(4'h1);
    drive_sym(4'h2);
    reset = 1'b1;
    lane_in = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_data1", data1_in, 0);
    check("midrst_data2", data2_in, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_err", frame_err, 0);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("midrst_no_pulse", (vcnt - v0) + (ecnt - e0), 0);
    do_frame("after_rst", 8'hA5, 8'h3C, 4'h0, 4'hF, 1'b1, 8'hA5, 8'h3C);
    md1 = 8'hA5; md2 = 8'h3C;

    for (int r = 0; r < 40; r++) begin
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      x  = d1[7:4] ^ d1[3:0] ^ d2[7:4] ^ d2[3:0];
      chk  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : x;
      stop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 14)) : 4'hF;
      ev = (stop == 4'hF) && (!CSUM || chk == x);
      if (ev) begin md1 = d1; md2 = d2; end
      do_frame($sformatf("rand%0d", r), d1, d2, chk, stop, ev, md1, md2);
    end

    check("never_both_pulses", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
